// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, enables and constants for the register file
package regfile_pkg;

   localparam int REG_BUS_WIDTH      = 32;
   localparam int REG_ADDR_BUS_WIDTH = 5;
   localparam int REG_NUM            = 32;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic READ_ENABLE   = 1'b1;
   localparam logic READ_DISABLE  = 1'b0;

   localparam logic [REG_BUS_WIDTH-1:0]      ZERO_WORD = '0;
   localparam logic [REG_ADDR_BUS_WIDTH-1:0] ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - writeback and two read ports of the register file
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = REG_BUS_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_BUS_WIDTH
);

   logic [DATA_WIDTH-1:0] rd_data_i;
   logic [ADDR_WIDTH-1:0] rd_addr_i;
   logic                  rd_enable_i;

   logic                  rs1_read_i;
   logic [ADDR_WIDTH-1:0] rs1_addr_i;
   logic [DATA_WIDTH-1:0] rs1_data_o;

   logic                  rs2_read_i;
   logic [ADDR_WIDTH-1:0] rs2_addr_i;
   logic [DATA_WIDTH-1:0] rs2_data_o;

   logic [31:0]           write_count_o;

   modport master (
      output rd_data_i, rd_addr_i, rd_enable_i,
      output rs1_read_i, rs1_addr_i,
      output rs2_read_i, rs2_addr_i,
      input  rs1_data_o, rs2_data_o, write_count_o
   );

   modport slave (
      input  rd_data_i, rd_addr_i, rd_enable_i,
      input  rs1_read_i, rs1_addr_i,
      input  rs2_read_i, rs2_addr_i,
      output rs1_data_o, rs2_data_o, write_count_o
   );

endinterface

// File: rtl/regfile.sv
// rtl/regfile.sv - 2-read/1-write register file, x0 hardwired, write-first bypass
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = REG_BUS_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_BUS_WIDTH,
   parameter int REG_NUM    = 2 ** ADDR_WIDTH
) (
   input  logic       clk,
   input  logic       rst,
   regfile_if.slave   bus
);

   logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
   logic [DATA_WIDTH-1:0] regs_d [REG_NUM];
   logic [31:0]           write_count_q;
   logic [31:0]           write_count_d;
   logic                  commit;

   // One read port; both ports use this same function so they cannot drift apart.
   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic                  in_reset,
      input logic                  rd_en,
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  wr_en,
      input logic [ADDR_WIDTH-1:0] wr_addr,
      input logic [DATA_WIDTH-1:0] wr_data,
      input logic [DATA_WIDTH-1:0] stored
   );
      logic [DATA_WIDTH-1:0] value;
      value = '0;
      if (!in_reset && rd_en == READ_ENABLE && addr != '0) begin
         if (wr_en == WRITE_ENABLE && wr_addr == addr) begin
            value = wr_data;
         end else begin
            value = stored;
         end
      end
      return value;
   endfunction

   always_comb begin
      commit        = (bus.rd_enable_i == WRITE_ENABLE) && (bus.rd_addr_i != '0);
      regs_d        = regs_q;
      write_count_d = write_count_q;
      if (commit) begin
         regs_d[bus.rd_addr_i] = bus.rd_data_i;
         write_count_d         = write_count_q + 32'd1;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q        <= '{default: '0};
         write_count_q <= '0;
      end else begin
         regs_q        <= regs_d;
         write_count_q <= write_count_d;
      end
   end

   assign bus.rs1_data_o = read_port(rst, bus.rs1_read_i, bus.rs1_addr_i,
                                     bus.rd_enable_i, bus.rd_addr_i, bus.rd_data_i,
                                     regs_q[bus.rs1_addr_i]);

   assign bus.rs2_data_o = read_port(rst, bus.rs2_read_i, bus.rs2_addr_i,
                                     bus.rd_enable_i, bus.rd_addr_i, bus.rd_data_i,
                                     regs_q[bus.rs2_addr_i]);

   assign bus.write_count_o = write_count_q;

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed and randomized checks of regfile against an array model
module tb_regfile;

   logic clk;
   logic rst;

   regfile_if bus ();

   regfile dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [31:0] model [32];
   logic [31:0] model_count;
   int          compared;
   int          mismatched;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] expect_read(input logic en, input logic [4:0] addr);
      if (rst || !en || addr == 5'd0) return 32'd0;
      if (bus.rd_enable_i && bus.rd_addr_i == addr) return bus.rd_data_i;
      return model[addr];
   endfunction

   // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
   task automatic cycle(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                        input string tag);
      rst             = r;
      bus.rd_enable_i = we;
      bus.rd_addr_i   = wa;
      bus.rd_data_i   = wd;
      bus.rs1_read_i  = e1;
      bus.rs1_addr_i  = a1;
      bus.rs2_read_i  = e2;
      bus.rs2_addr_i  = a2;
      @(negedge clk);
      chk({tag, ".rs1"}, bus.rs1_data_o, expect_read(e1, a1));
      chk({tag, ".rs2"}, bus.rs2_data_o, expect_read(e2, a2));
      chk({tag, ".cnt"}, bus.write_count_o, model_count);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 32; i++) model[i] = 32'd0;
         model_count = 32'd0;
      end else if (we && wa != 5'd0) begin
         model[wa]   = wd;
         model_count = model_count + 32'd1;
      end
      #1;
   endtask

   initial begin
      compared    = 0;
      mismatched  = 0;
      model_count = 32'd0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      rst             = 1'b1;
      bus.rd_enable_i = 1'b0;
      bus.rd_addr_i   = '0;
      bus.rd_data_i   = '0;
      bus.rs1_read_i  = 1'b0;
      bus.rs1_addr_i  = '0;
      bus.rs2_read_i  = 1'b0;
      bus.rs2_addr_i  = '0;
      @(posedge clk);
      #1;

      // Reset held two cycles, a write attempted during it, then reads of x1/x31.
      cycle(1, 1, 5'd2, 32'h1111_2222, 1, 5'd1, 1, 5'd31, "rst0");
      cycle(1, 0, 5'd0, 32'h0,         1, 5'd2, 1, 5'd2,  "rst1");
      cycle(0, 0, 5'd0, 32'h0,         1, 5'd1, 1, 5'd31, "post_rst_a");
      cycle(0, 0, 5'd0, 32'h0,         1, 5'd31, 1, 5'd1, "post_rst_b");
      chk("cnt_after_reset", bus.write_count_o, 32'd0);

      cycle(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 0, 5'd0, "wr_x5");
      cycle(0, 0, 5'd0, 32'h0,         1, 5'd5, 1, 5'd5, "rd_x5");
      chk("x5_value", bus.rs1_data_o, 32'hDEAD_BEEF);
      chk("cnt_one", bus.write_count_o, 32'd1);

      cycle(0, 1, 5'd0, 32'h1234_5678, 1, 5'd0, 1, 5'd0, "wr_x0");
      cycle(0, 0, 5'd0, 32'h0,         1, 5'd0, 1, 5'd0, "rd_x0");
      chk("cnt_x0_unchanged", bus.write_count_o, 32'd1);

      rst = 0;
      bus.rd_enable_i = 1; bus.rd_addr_i = 5'd7; bus.rd_data_i = 32'hA5A5_A5A5;
      bus.rs1_read_i = 1; bus.rs1_addr_i = 5'd7; bus.rs2_read_i = 1; bus.rs2_addr_i = 5'd7;
      #1;
      chk("bypass_rs1", bus.rs1_data_o, 32'hA5A5_A5A5);
      chk("bypass_rs2", bus.rs2_data_o, 32'hA5A5_A5A5);
      cycle(0, 1, 5'd7, 32'hA5A5_A5A5, 1, 5'd7, 1, 5'd7, "bypass");

      cycle(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd5, "rs2_disabled");
      cycle(0, 1, 5'd9, 32'd1, 1, 5'd9, 0, 5'd0, "x9_first");
      cycle(0, 1, 5'd9, 32'd2, 1, 5'd9, 1, 5'd9, "x9_second");
      cycle(0, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd7, "x9_final");
      chk("x9_is_2", bus.rs1_data_o, 32'd2);

      cycle(0, 1, 5'd3, 32'd7, 0, 5'd0, 0, 5'd0, "wr_x3");
      cycle(1, 1, 5'd4, 32'd9, 1, 5'd3, 1, 5'd4, "rst_mid");
      cycle(0, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd4, "after_mid_rst");
      chk("x3_cleared", bus.rs1_data_o, 32'd0);
      chk("x4_discarded", bus.rs2_data_o, 32'd0);
      chk("cnt_cleared", bus.write_count_o, 32'd0);

      for (int n = 0; n < 400; n++) begin
         logic [4:0]  wa;
         logic [4:0]  a1;
         logic [4:0]  a2;
         wa = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
               ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and every data port.
REQ-002 Parameter ADDR_WIDTH, default 5, width of every register address port.
REQ-003 Parameter REG_NUM, default 32, number of architectural registers, equal to 2**ADDR_WIDTH.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 rd_data_i  input  DATA_WIDTH  writeback data from the MEM/WB stage register.
REQ-008 rd_addr_i  input  ADDR_WIDTH  writeback destination register index.
REQ-009 rd_enable_i  input  1  writeback request; 1 = write this cycle.
REQ-010 rs1_read_i  input  1  read-port-1 enable from decode.
REQ-011 rs1_addr_i  input  ADDR_WIDTH  read-port-1 register index.
REQ-012 rs1_data_o  output  DATA_WIDTH  read-port-1 data, combinational.
REQ-013 rs2_read_i  input  1  read-port-2 enable from decode.
REQ-014 rs2_addr_i  input  ADDR_WIDTH  read-port-2 register index.
REQ-015 rs2_data_o  output  DATA_WIDTH  read-port-2 data, combinational.
REQ-016 write_count_o  output  32  count of committed architectural writes, for debug and performance monitoring.

Function
REQ-017 Storage: REG_NUM x DATA_WIDTH registers; register 0 is hardwired to zero.
REQ-018 Write: on a rising edge with rst=0, rd_enable_i=1 and rd_addr_i!=0, reg[rd_addr_i] SHALL take rd_data_i.
REQ-019 A write with rd_addr_i=0 SHALL be discarded and SHALL NOT increment write_count_o.
REQ-020 Write latency: the new value is architecturally visible from the cycle after the write edge.
REQ-021 Read: rsN_data_o SHALL be 0 when rst=1, when rsN_read_i=0, or when rsN_addr_i=0.
REQ-022 Bypass: when rsN_read_i=1, rd_enable_i=1 and rsN_addr_i==rd_addr_i!=0 in the same cycle, rsN_data_o SHALL equal rd_data_i (write-first).
REQ-023 Otherwise, rsN_data_o SHALL be reg[rsN_addr_i].
REQ-024 Both read ports are independent; both SHALL bypass simultaneously when both addresses match rd_addr_i.
REQ-025 write_count_o SHALL increment by 1 on each committed write (REQ-018) and wrap from 0xFFFFFFFF to 0.
REQ-026 Back-to-back writes to the same index on consecutive cycles: the later write SHALL win; a read in the second cycle SHALL return the second cycle's rd_data_i.
REQ-027 The block has no stall input: squashing a write is the upstream stage's job, signalled by rd_enable_i=0.

Reset
REQ-028 While rst=1 at a rising edge, all registers SHALL clear to 0 and write_count_o SHALL clear to 0.
REQ-029 A write presented in a reset cycle SHALL be discarded.
REQ-030 During rst=1 both read outputs SHALL read 0, with no bypass.
REQ-031 After reset deasserts, every register SHALL read 0 until it is written.

Structure
REQ-032 The shared defines header SHALL hold Zero, WriteEnable/WriteDisable, ReadEnable/ReadDisable, RegAddrBus and RegBus widths, and RegNum.
REQ-033 The block uses no sub-modules, because it is a single array with its read muxes.
REQ-034 The read-port logic SHALL be duplicated per port, and each copy SHALL be identical.

Verification
REQ-035 Reset and read: hold rst=1 for 2 cycles, release, then read x1 and x31 -> 0 on both ports, write_count_o=0.
REQ-036 Write then read: write x5=0xDEADBEEF, next cycle read rs1=x5 -> 0xDEADBEEF, write_count_o=1.
REQ-037 x0 write: write x0=0x12345678, then read rs1=x0 and rs2=x0 -> 0 on both, write_count_o unchanged.
REQ-038 Bypass: write x7=0xA5A5A5A5 while rs1=x7 and rs2=x7 in the same cycle -> both outputs 0xA5A5A5A5 that cycle.
REQ-039 Read enable and collision: rs2_read_i=0 with rs2=x5 -> 0; write x9=1 then x9=2 on consecutive cycles -> x9 reads 2.
REQ-040 Reset mid-operation: write x3=7, assert rst for 1 cycle with a concurrent write of x4=9 -> x3=0, x4=0, write_count_o=0.
